// File: rtl/hdmi_sched_pkg.sv
// Shared types and constants for the HDMI data-island packet scheduler.
package hdmi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    LEAD_GUARD,
    PACKET,
    TRAIL_GUARD
  } sched_state_t;

  localparam int SLOT_LEN = 32;
  localparam int HEADER_W = 24;
  localparam int SUB_W    = 56;
  localparam int NUM_SUB  = 4;

  // Blanking needed to open an island that can carry at least one packet.
  function automatic int min_start_cycles(input int preamble_len, input int guard_len);
    return preamble_len + 2 * guard_len + SLOT_LEN;
  endfunction

  // Blanking needed at slot 31 to fit one more packet plus the trailing guard.
  function automatic int min_continue_cycles(input int guard_len);
    return SLOT_LEN + guard_len + 1;
  endfunction

endpackage

// File: rtl/hdmi_rr_arbiter.sv
// Round-robin request arbiter; HDMI_SCHED_PRIORITY_EN gives source 0 fixed top priority
// with the remaining sources rotating among themselves.
module hdmi_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [PW-1:0]      next_ptr
);

  logic found;
  int   idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
`ifdef HDMI_SCHED_PRIORITY_EN
    if (req[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end else begin
      // Pointer value 0 is treated as 1 so the rotation only covers sources 1..N-1.
      for (int k = 0; k < NUM_SRC - 1; k++) begin
        idx = 1 + (((int'(ptr) == 0 ? 1 : int'(ptr)) - 1 + k) % (NUM_SRC - 1));
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
          next_ptr   = PW'((idx == NUM_SRC - 1) ? 1 : idx + 1);
        end
      end
    end
`else
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        next_ptr   = PW'((idx + 1) % NUM_SRC);
      end
    end
`endif
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Data-island sequencer: preamble, guard bands and back-to-back 32-pixel packet slots.
// Arbitration mode selected by HDMI_SCHED_PRIORITY_EN (see hdmi_rr_arbiter).
module hdmi_packet_scheduler
  import hdmi_sched_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int MAX_PACKETS  = 18,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic                                   clk_pixel,
  input  logic                                   reset,
  input  logic                                   blank,
  input  logic [11:0]                            cycles_remaining,
  input  logic [NUM_SRC-1:0]                     req,
  input  logic [NUM_SRC-1:0][HEADER_W-1:0]       header_in,
  input  logic [NUM_SRC-1:0][NUM_SUB-1:0][SUB_W-1:0] sub_in,
  output logic [NUM_SRC-1:0]                     grant,
  output logic [HEADER_W-1:0]                    header,
  output logic [NUM_SUB-1:0][SUB_W-1:0]          sub,
  output logic                                   packet_enable,
  output logic                                   preamble,
  output logic                                   guard,
  output logic                                   data_island
);

  localparam int PW        = $clog2(NUM_SRC);
  localparam int CW        = $clog2(MAX_PACKETS + 1);
  localparam int PHASE_MAX = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int PHW       = $clog2(PHASE_MAX) + 1;
  localparam logic [11:0]    START_MIN    = 12'(min_start_cycles(PREAMBLE_LEN, GUARD_LEN));
  localparam logic [11:0]    CONT_MIN     = 12'(min_continue_cycles(GUARD_LEN));
  localparam logic [PHW-1:0] PREAMBLE_END = PHW'(PREAMBLE_LEN - 1);
  localparam logic [PHW-1:0] GUARD_END    = PHW'(GUARD_LEN - 1);

  sched_state_t                  state;
  logic [PHW-1:0]                phase_cnt;
  logic [4:0]                    slot_cnt;
  logic [CW-1:0]                 pkt_count;
  logic [PW-1:0]                 ptr;
  logic [NUM_SRC-1:0]            arb_grant;
  logic [PW-1:0]                 arb_next_ptr;
  logic                          decide;
  logic                          take;
  logic [HEADER_W-1:0]           win_header;
  logic [NUM_SUB-1:0][SUB_W-1:0] win_sub;

  hdmi_rr_arbiter #(.NUM_SRC(NUM_SRC), .PW(PW)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .grant    (arb_grant),
    .next_ptr (arb_next_ptr)
  );

  // Decision points: last lead-guard cycle, or slot 31 when another packet still fits.
  assign decide = (state == LEAD_GUARD && phase_cnt == GUARD_END) ||
                  (state == PACKET && slot_cnt == 5'd31 &&
                   pkt_count < CW'(MAX_PACKETS) && cycles_remaining >= CONT_MIN);
  assign take  = decide && (|req) && !reset;
  assign grant = take ? arb_grant : '0;

  always_comb begin
    win_header = '0;
    win_sub    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_grant[i]) begin
        win_header = header_in[i];
        win_sub    = sub_in[i];
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      slot_cnt      <= '0;
      pkt_count     <= '0;
      ptr           <= '0;
      header        <= '0;
      sub           <= '0;
      packet_enable <= 1'b0;
      preamble      <= 1'b0;
      guard         <= 1'b0;
      data_island   <= 1'b0;
    end else begin
      if (take) begin
        header <= win_header;
        sub    <= win_sub;
        ptr    <= arb_next_ptr;
        if (pkt_count != CW'(MAX_PACKETS)) pkt_count <= pkt_count + 1'b1;
      end
      case (state)
        IDLE: begin
          pkt_count <= '0;
          if (blank && (|req) && cycles_remaining >= START_MIN) begin
            state     <= PREAMBLE;
            phase_cnt <= '0;
            preamble  <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (!blank) begin
            state    <= IDLE;
            preamble <= 1'b0;
          end else if (phase_cnt == PREAMBLE_END) begin
            state       <= LEAD_GUARD;
            phase_cnt   <= '0;
            preamble    <= 1'b0;
            guard       <= 1'b1;
            data_island <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        LEAD_GUARD: begin
          if (phase_cnt == GUARD_END) begin
            phase_cnt <= '0;
            if (take) begin
              state         <= PACKET;
              slot_cnt      <= '0;
              guard         <= 1'b0;
              packet_enable <= 1'b1;
            end else begin
              state <= TRAIL_GUARD;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        PACKET: begin
          // The counter wraps 31->0 on its own, giving a gapless follow-on slot.
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_cnt == 5'd31 && !take) begin
            state         <= TRAIL_GUARD;
            phase_cnt     <= '0;
            packet_enable <= 1'b0;
            guard         <= 1'b1;
          end
        end
        TRAIL_GUARD: begin
          if (phase_cnt == GUARD_END) begin
            state       <= IDLE;
            guard       <= 1'b0;
            data_island <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed self-checking bench for hdmi_packet_scheduler at default parameters.
module tb_hdmi_packet_scheduler;

  logic                       clk_pixel = 1'b0;
  logic                       reset;
  logic                       blank;
  logic [11:0]                cycles_remaining;
  logic [3:0]                 req;
  logic [3:0][23:0]           header_in;
  logic [3:0][3:0][55:0]      sub_in;
  logic [3:0]                 grant;
  logic [23:0]                header;
  logic [3:0][55:0]           sub;
  logic                       packet_enable;
  logic                       preamble;
  logic                       guard;
  logic                       data_island;

  int n_checks = 0;
  int n_fail   = 0;
  int di_cnt   = 0;
  int pe_cnt   = 0;
  int pre_cnt  = 0;
  int pe_run   = 0;
  int last_run = 0;
  int gnt_q[$];
  int b_di, b_pe, b_pre, b_g;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_packet_scheduler dut (
    .clk_pixel        (clk_pixel),
    .reset            (reset),
    .blank            (blank),
    .cycles_remaining (cycles_remaining),
    .req              (req),
    .header_in        (header_in),
    .sub_in           (sub_in),
    .grant            (grant),
    .header           (header),
    .sub              (sub),
    .packet_enable    (packet_enable),
    .preamble         (preamble),
    .guard            (guard),
    .data_island      (data_island)
  );

  // Mid-cycle activity monitor: phase cycle counts, enable run lengths and grant order.
  always @(negedge clk_pixel) begin
    if (data_island) di_cnt++;
    if (preamble) pre_cnt++;
    if (packet_enable) begin
      pe_cnt++;
      pe_run++;
    end else begin
      if (pe_run != 0) last_run = pe_run;
      pe_run = 0;
    end
    for (int i = 0; i < 4; i++) if (grant[i]) gnt_q.push_back(i);
  end

  function automatic int gnt_at(input int n);
    return (gnt_q.size() > n) ? gnt_q[n] : -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps n cycles; with drop set, a source withdraws its request once granted.
  task automatic applyStimulus(input int n, input bit drop);
    logic [3:0] g;
    for (int i = 0; i < n; i++) begin
      g = grant;
      @(posedge clk_pixel);
      #1;
      if (drop) req = req & ~g;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    blank = 1'b0;
    req = '0;
    cycles_remaining = '0;
    applyStimulus(2, 1'b0);
    reset = 1'b0;
  endtask

  task automatic snap();
    b_di  = di_cnt;
    b_pe  = pe_cnt;
    b_pre = pre_cnt;
    b_g   = gnt_q.size();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      header_in[i] = 24'h100000 * 24'(i + 1) + 24'h0000A5;
      for (int j = 0; j < 4; j++) sub_in[i][j] = 56'h11_2233_4455_6600 + 56'(i * 4 + j);
    end

    $display("[TB] reset state");
    doReset();
    checkOutput("reset_outputs", {grant, packet_enable, preamble, guard, data_island}, '0);
    checkOutput("reset_header", header, '0);
    checkOutput("reset_sub", sub, '0);

    $display("[TB] single request");
    blank = 1'b1; cycles_remaining = 12'd200; req = 4'b0010;
    snap();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1'b1);
      checkOutput("t1_preamble", {preamble, guard}, 2'b10);
    end
    applyStimulus(1, 1'b1);
    checkOutput("t1_lead_guard", {guard, data_island, preamble}, 3'b110);
    checkOutput("t1_no_early_grant", grant, 4'b0000);
    applyStimulus(1, 1'b1);
    checkOutput("t1_grant", grant, 4'b0010);
    applyStimulus(1, 1'b1);
    checkOutput("t1_pe_start", {packet_enable, guard}, 2'b10);
    checkOutput("t1_header", header, header_in[1]);
    checkOutput("t1_sub", sub, sub_in[1]);
    applyStimulus(31, 1'b1);
    checkOutput("t1_slot31", {packet_enable, grant}, 5'b10000);
    applyStimulus(1, 1'b1);
    checkOutput("t1_trail", {packet_enable, guard, data_island}, 3'b011);
    applyStimulus(2, 1'b1);
    checkOutput("t1_idle", {guard, data_island, preamble}, 3'b000);
    checkOutput("t1_di_cycles", di_cnt - b_di, 36);
    checkOutput("t1_pe_cycles", pe_cnt - b_pe, 32);
    checkOutput("t1_pre_cycles", pre_cnt - b_pre, 8);
    checkOutput("t1_grant_count", gnt_q.size() - b_g, 1);

    $display("[TB] back-to-back");
    doReset();
    blank = 1'b1; cycles_remaining = 12'd500; req = 4'b1111;
    snap();
    applyStimulus(150, 1'b1);
    for (int k = 0; k < 4; k++) checkOutput("t2_order", gnt_at(b_g + k), k);
    checkOutput("t2_grant_count", gnt_q.size() - b_g, 4);
    checkOutput("t2_pe_cycles", pe_cnt - b_pe, 128);
    checkOutput("t2_pe_contiguous", last_run, 128);
    checkOutput("t2_di_cycles", di_cnt - b_di, 132);
    checkOutput("t2_last_header", header, header_in[3]);

    $display("[TB] packet limit");
    doReset();
    blank = 1'b1; cycles_remaining = 12'd2000; req = 4'b1111;
    snap();
    applyStimulus(588, 1'b0);
    checkOutput("t3_trail_end", {guard, data_island, packet_enable}, 3'b110);
    applyStimulus(1, 1'b0);
    checkOutput("t3_idle_gap", {preamble, guard, data_island}, 3'b000);
    applyStimulus(1, 1'b0);
    checkOutput("t3_restart", preamble, 1'b1);
    checkOutput("t3_grant_count", gnt_q.size() - b_g, 18);
    checkOutput("t3_last_src", gnt_at(b_g + 17), 1);
    checkOutput("t3_pe_cycles", pe_cnt - b_pe, 576);
    checkOutput("t3_pe_contiguous", last_run, 576);
    checkOutput("t3_di_cycles", di_cnt - b_di, 580);

    $display("[TB] insufficient blanking");
    doReset();
    blank = 1'b1; cycles_remaining = 12'd43; req = 4'b0100;
    snap();
    applyStimulus(20, 1'b0);
    checkOutput("t4_no_preamble", pre_cnt - b_pre, 0);
    checkOutput("t4_no_grant", gnt_q.size() - b_g, 0);
    cycles_remaining = 12'd44;
    applyStimulus(1, 1'b0);
    checkOutput("t4_start_at_44", preamble, 1'b1);
    req = 4'b0110; cycles_remaining = 12'd34;
    applyStimulus(41, 1'b1);
    checkOutput("t4_slot31", {packet_enable, grant}, 5'b10000);
    applyStimulus(1, 1'b1);
    checkOutput("t4_trail", {packet_enable, guard}, 2'b01);
    applyStimulus(4, 1'b1);
    checkOutput("t4_idle", {preamble, data_island}, 2'b00);
    checkOutput("t4_grant_count", gnt_q.size() - b_g, 1);
    checkOutput("t4_grant_src", gnt_at(b_g), 1);

    $display("[TB] reset mid-packet");
    doReset();
    blank = 1'b1; cycles_remaining = 12'd200; req = 4'b0001;
    applyStimulus(21, 1'b1);
    checkOutput("t5_slot10", packet_enable, 1'b1);
    reset = 1'b1;
    applyStimulus(1, 1'b1);
    checkOutput("t5_abort_flags", {grant, packet_enable, preamble, guard, data_island}, '0);
    checkOutput("t5_abort_header", header, '0);
    checkOutput("t5_abort_sub", sub, '0);
    reset = 1'b0; req = 4'b0011;
    snap();
    applyStimulus(20, 1'b1);
    checkOutput("t5_ptr_restart", gnt_at(b_g), 0);

    $display("[TB] arbitration order");
    doReset();
    blank = 1'b1; cycles_remaining = 12'd500; req = 4'b1111;
    snap();
    applyStimulus(106, 1'b0);
`ifdef HDMI_SCHED_PRIORITY_EN
    for (int k = 0; k < 3; k++) checkOutput("t6_priority_order", gnt_at(b_g + k), 0);
`else
    for (int k = 0; k < 3; k++) checkOutput("t6_rr_order", gnt_at(b_g + k), k);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
